// File: rtl/audio_codec_emulator.sv
// Codec side of an I2S audio link: drives BCLK and LRC as master and shifts one stereo ADC
// sample pair out per frame. It also collects the DAC sample pair arriving on dacdat.
module audio_codec_emulator #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] adc_left,
    input  logic [DATA_W-1:0] adc_right,
    output logic              adc_load,
    output logic [DATA_W-1:0] dac_left,
    output logic [DATA_W-1:0] dac_right,
    output logic              dac_valid,
    output logic              bclk,
    output logic              adclrc,
    output logic              daclrc,
    output logic              adcdat,
    input  logic              dacdat
);

    localparam int DIV_W = $clog2(BCLK_DIV + 1);
    localparam int BIT_W = $clog2(2 * SLOT_W);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_next;
    logic [DATA_W-1:0] held_left;
    logic [DATA_W-1:0] held_right;
    logic [DATA_W-1:0] rx_left;
    logic [DATA_W-1:0] rx_right;
    logic [DATA_W-1:0] rx_mask;
    logic              div_wrap;
    logic              run_on;
    logic              tx_next;

    // Bit q of a slot carries sample bit DATA_W-q; q = 0 is the I2S one-bit delay slot.
    function automatic logic tx_bit(input logic [BIT_W-1:0] cnt,
                                    input logic [DATA_W-1:0] left,
                                    input logic [DATA_W-1:0] right);
        int                c;
        int                q;
        logic [DATA_W-1:0] s;
        c = int'(cnt);
        if (c >= SLOT_W) begin
            q = c - SLOT_W;
            s = right;
        end else begin
            q = c;
            s = left;
        end
        tx_bit = 1'b0;
        if (q >= 1 && q <= DATA_W) begin
            s = s << (q - 1);
            tx_bit = s[DATA_W-1];
        end
    endfunction

    function automatic logic [DATA_W-1:0] slot_mask(input logic [BIT_W-1:0] cnt);
        int q;
        q = int'(cnt) % SLOT_W;
        slot_mask = '0;
        if (q >= 1 && q <= DATA_W)
            slot_mask = DATA_W'(1) << (DATA_W - q);
    endfunction

    assign div_wrap = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign bit_next = (bit_cnt == BIT_W'(2 * SLOT_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
    assign tx_next  = tx_bit(bit_next, held_left, held_right);
    assign rx_mask  = slot_mask(bit_cnt);
    assign run_on   = (state == RUN) && enable;
    assign daclrc   = adclrc;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            bclk       <= 1'b0;
            adclrc     <= 1'b0;
            adcdat     <= 1'b0;
            adc_load   <= 1'b0;
            dac_valid  <= 1'b0;
            held_left  <= '0;
            held_right <= '0;
            rx_left    <= '0;
            rx_right   <= '0;
            dac_left   <= '0;
            dac_right  <= '0;
        end else begin
            adc_load  <= 1'b0;
            dac_valid <= 1'b0;
            if (!run_on) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                bclk    <= 1'b0;
                adclrc  <= 1'b0;
                adcdat  <= 1'b0;
                // Entering RUN opens a fresh frame; any partial receive data is never published.
                if (state == IDLE && enable) begin
                    held_left  <= adc_left;
                    held_right <= adc_right;
                    adc_load   <= 1'b1;
                end
            end else if (!div_wrap) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
                bclk    <= ~bclk;
                if (bclk) begin
                    bit_cnt <= bit_next;
                    adclrc  <= (int'(bit_next) >= SLOT_W);
                    adcdat  <= tx_next;
                    if (bit_next == '0) begin
                        held_left  <= adc_left;
                        held_right <= adc_right;
                        adc_load   <= 1'b1;
                        dac_left   <= rx_left;
                        dac_right  <= rx_right;
                        dac_valid  <= 1'b1;
                    end
                end else if (int'(bit_cnt) < SLOT_W) begin
                    rx_left <= dacdat ? (rx_left | rx_mask) : (rx_left & ~rx_mask);
                end else begin
                    rx_right <= dacdat ? (rx_right | rx_mask) : (rx_right & ~rx_mask);
                end
            end
        end
    end

endmodule
